reg_write_uart_tx: RTL and testbench



---
 rtl/reg_write_uart_tx.sv | 131 +++++++++++++
 tb/tb_reg_write_uart_tx.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_write_uart_tx.sv
// Host-side UART register-write initiator: one accepted request becomes two
// back-to-back 8N1 frames on tx_out, the address byte first and then the data byte.
module reg_write_uart_tx #(
  parameter int CLKS_PER_BIT = 142,
  parameter int GAP_CYCLES   = 0
) (
  input  logic       clk_in,
  input  logic       rst_in_n,
  input  logic       req_valid_in,
  output logic       req_ready_out,
  input  logic [2:0] req_addr_in,
  input  logic [7:0] req_data_in,
  output logic       tx_out,
  output logic       busy_out,
  output logic       done_out
);

  // A single counter serves as the baud counter and as the gap timer.
  localparam int MAX_CNT = (CLKS_PER_BIT > GAP_CYCLES) ? CLKS_PER_BIT : GAP_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] GAP   = 3'd4;

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift_reg;
  logic [7:0]       data_byte;
  logic             byte_sel;

  // Each output is registered and is set one cycle ahead of the line state it reflects.
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      state         <= IDLE;
      cnt           <= '0;
      bit_cnt       <= '0;
      shift_reg     <= '0;
      data_byte     <= '0;
      byte_sel      <= 1'b0;
      tx_out        <= 1'b1;
      req_ready_out <= 1'b1;
      busy_out      <= 1'b0;
      done_out      <= 1'b0;
    end else begin
      done_out <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid_in && req_ready_out) begin
            shift_reg     <= {5'b00000, req_addr_in};
            data_byte     <= req_data_in;
            byte_sel      <= 1'b0;
            cnt           <= '0;
            tx_out        <= 1'b0;
            req_ready_out <= 1'b0;
            busy_out      <= 1'b1;
            state         <= START;
          end
        end
        START: begin
          if (cnt == BAUD_LAST) begin
            cnt     <= '0;
            bit_cnt <= '0;
            tx_out  <= shift_reg[0];
            state   <= DATA;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (cnt == BAUD_LAST) begin
            cnt <= '0;
            if (bit_cnt == 3'd7) begin
              tx_out <= 1'b1;
              state  <= STOP;
            end else begin
              bit_cnt   <= bit_cnt + 3'd1;
              tx_out    <= shift_reg[1];
              shift_reg <= {1'b0, shift_reg[7:1]};
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (cnt == BAUD_LAST) begin
            cnt <= '0;
            if (!byte_sel) begin
              byte_sel  <= 1'b1;
              shift_reg <= data_byte;
              if (GAP_CYCLES > 0) begin
                state <= GAP;
              end else begin
                tx_out <= 1'b0;
                state  <= START;
              end
            end else begin
              req_ready_out <= 1'b1;
              busy_out      <= 1'b0;
              done_out      <= 1'b1;
              state         <= IDLE;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            cnt    <= '0;
            tx_out <= 1'b0;
            state  <= START;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state         <= IDLE;
          tx_out        <= 1'b1;
          req_ready_out <= 1'b1;
          busy_out      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_write_uart_tx.sv
// Directed bench for reg_write_uart_tx: frame bit patterns, handshake timing,
// the inter-frame gap, back-to-back requests and asynchronous abort.
module tb_reg_write_uart_tx;

  localparam int CPB = 4;

  logic       clk_in = 1'b0;
  logic       rst_in_n;
  logic       req_valid, req_ready, tx, busy, done;
  logic [2:0] req_addr;
  logic [7:0] req_data;
  logic       g_valid, g_ready, g_tx, g_busy, g_done;
  logic [2:0] g_addr;
  logic [7:0] g_data;

  int checks = 0;
  int failures = 0;

  always #5 clk_in = ~clk_in;

  reg_write_uart_tx #(.CLKS_PER_BIT(CPB), .GAP_CYCLES(0)) dut (
    .clk_in(clk_in), .rst_in_n(rst_in_n),
    .req_valid_in(req_valid), .req_ready_out(req_ready),
    .req_addr_in(req_addr), .req_data_in(req_data),
    .tx_out(tx), .busy_out(busy), .done_out(done)
  );

  reg_write_uart_tx #(.CLKS_PER_BIT(CPB), .GAP_CYCLES(5)) dut_gap (
    .clk_in(clk_in), .rst_in_n(rst_in_n),
    .req_valid_in(g_valid), .req_ready_out(g_ready),
    .req_addr_in(g_addr), .req_data_in(g_data),
    .tx_out(g_tx), .busy_out(g_busy), .done_out(g_done)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk_in);
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    @(posedge clk_in);
    #1 req_valid = 1'b0;
  endtask

  // Cycle k is the k-th cycle after the accept edge; bits are sampled mid-bit.
  task automatic watchTransaction(input string tag, input logic [0:19] frame, input bit chain,
                                  input logic [2:0] na, input logic [7:0] nd);
    int done_early;
    int ready_high;
    done_early = 0;
    ready_high = 0;
    for (int k = 1; k <= 81; k++) begin
      @(negedge clk_in);
      if (k == 1) checkOutput({tag, "_start_first"}, 32'(tx), 32'd0);
      if (k <= 80) begin
        if ((k - 1) % CPB == 1)
          checkOutput($sformatf("%s_bit%0d", tag, (k - 1) / CPB), 32'(tx), 32'(frame[(k - 1) / CPB]));
        if (done) done_early++;
        if (req_ready) ready_high++;
      end else begin
        checkOutput({tag, "_done81"}, 32'(done), 32'd1);
        checkOutput({tag, "_ready81"}, 32'(req_ready), 32'd1);
        checkOutput({tag, "_busy81"}, 32'(busy), 32'd0);
        checkOutput({tag, "_idle81"}, 32'(tx), 32'd1);
        if (chain) begin
          req_valid = 1'b1;
          req_addr  = na;
          req_data  = nd;
        end
      end
    end
    checkOutput({tag, "_done_early"}, 32'(done_early), 32'd0);
    checkOutput({tag, "_ready_low"}, 32'(ready_high), 32'd0);
    if (chain) begin
      @(posedge clk_in);
      #1 req_valid = 1'b0;
    end else begin
      @(negedge clk_in);
      checkOutput({tag, "_done_single"}, 32'(done), 32'd0);
    end
  endtask

  int         acc_t[$];
  logic [2:0] acc_a[$];
  logic [7:0] acc_d[$];
  logic       tx_log[0:179];
  logic       g_log[1:90];
  logic [7:0] got_a, got_d;
  int         hi_cnt, dn_cnt;

  initial begin
    rst_in_n  = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_data  = '0;
    g_valid   = 1'b0;
    g_addr    = '0;
    g_data    = '0;
    repeat (3) @(negedge clk_in);
    checkOutput("rst_tx", 32'(tx), 32'd1);
    checkOutput("rst_ready", 32'(req_ready), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    rst_in_n = 1'b1;
    repeat (2) @(negedge clk_in);
    checkOutput("post_rst_tx", 32'(tx), 32'd1);
    checkOutput("post_rst_ready", 32'(req_ready), 32'd1);

    // Single write: addr 3, data 0xA5
    applyStimulus(3'd3, 8'hA5);
    watchTransaction("t1", 20'b0110000001_0101001011, 1'b0, 3'd0, 8'h00);

    // Back-to-back: accept in the done cycle
    applyStimulus(3'd1, 8'h80);
    watchTransaction("t6a", 20'b0100000001_0000000011, 1'b1, 3'd7, 8'h00);
    watchTransaction("t6b", 20'b0111000001_0000000001, 1'b0, 3'd0, 8'h00);

    // Held valid with changing payload
    for (int t = 0; t < 180; t++) begin
      @(negedge clk_in);
      tx_log[t] = tx;
      if (t < 150) begin
        req_valid = 1'b1;
        req_addr  = 3'(t) ^ 3'd5;
        req_data  = 8'(t * 37 + 11);
        if (req_ready) begin
          acc_t.push_back(t);
          acc_a.push_back(req_addr);
          acc_d.push_back(req_data);
        end
      end else begin
        req_valid = 1'b0;
      end
    end
    checkOutput("t2_accepts", 32'(acc_t.size()), 32'd2);
    if (acc_t.size() >= 2) checkOutput("t2_spacing", 32'(acc_t[1] - acc_t[0]), 32'd81);
    for (int i = 0; i < acc_t.size() && i < 2; i++) begin
      if (acc_t[i] < 100) begin
        for (int b = 0; b < 8; b++) begin
          got_a[b] = tx_log[acc_t[i] + CPB * (1 + b) + 2];
          got_d[b] = tx_log[acc_t[i] + CPB * (11 + b) + 2];
        end
        checkOutput($sformatf("t2_addr%0d", i), 32'(got_a), 32'({5'b00000, acc_a[i]}));
        checkOutput($sformatf("t2_data%0d", i), 32'(got_d), 32'(acc_d[i]));
      end else begin
        checkOutput($sformatf("t2_late_accept%0d", i), 32'(acc_t[i]), 32'd0);
      end
    end

    // Inter-frame gap of 5 cycles: addr 0, data 0xFF
    @(negedge clk_in);
    g_valid = 1'b1;
    g_addr  = 3'd0;
    g_data  = 8'hFF;
    @(posedge clk_in);
    #1 g_valid = 1'b0;
    dn_cnt = 0;
    for (int k = 1; k <= 90; k++) begin
      @(negedge clk_in);
      g_log[k] = g_tx;
      if (k < 86 && g_done) dn_cnt++;
      if (k == 86) checkOutput("t3_done86", 32'(g_done), 32'd1);
    end
    hi_cnt = 0;
    for (int k = 37; k <= 45; k++) if (g_log[k]) hi_cnt++;
    checkOutput("t3_gap_high", 32'(hi_cnt), 32'd9);
    checkOutput("t3_first_start", 32'(g_log[1]), 32'd0);
    checkOutput("t3_last_addr_bit", 32'(g_log[36]), 32'd0);
    checkOutput("t3_data_start", 32'(g_log[46]), 32'd0);
    checkOutput("t3_data_bit0", 32'(g_log[50]), 32'd1);
    checkOutput("t3_done_early", 32'(dn_cnt), 32'd0);

    // Asynchronous abort in cycle 30
    applyStimulus(3'd6, 8'h5A);
    repeat (30) @(negedge clk_in);
    checkOutput("t4_pre_tx", 32'(tx), 32'd0);
    rst_in_n = 1'b0;
    #1;
    checkOutput("t4_abort_tx", 32'(tx), 32'd1);
    checkOutput("t4_abort_ready", 32'(req_ready), 32'd1);
    checkOutput("t4_abort_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk_in);
    rst_in_n = 1'b1;
    hi_cnt = 0;
    dn_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_in);
      if (tx && req_ready) hi_cnt++;
      if (done) dn_cnt++;
    end
    checkOutput("t4_no_resume", 32'(hi_cnt), 32'd20);
    checkOutput("t4_no_done", 32'(dn_cnt), 32'd0);
    applyStimulus(3'd6, 8'h5A);
    watchTransaction("t4", 20'b0011000001_0010110101, 1'b0, 3'd0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
